// File: rtl/rv_g_pkg.sv
// Shared types and constants for the rv_g write-back path.
package rv_g_pkg;

    // Default register widths; the write-back payload is sized for the wider of the two.
    localparam int unsigned DefXlen = 64;
    localparam int unsigned DefFlen = 32;
    localparam int unsigned WbDataW = (DefFlen > DefXlen) ? DefFlen : DefXlen;

    // Destination address layout: bit 5 selects the F file, bits 4:0 index it.
    localparam int unsigned AddrW   = 6;
    localparam int unsigned FSelBit = 5;
    localparam logic [AddrW-1:0] AddrX0 = '0;

    // One buffered write-back request.
    typedef struct packed {
        logic [AddrW-1:0]   addr;
        logic [WbDataW-1:0] data;
    } wb_req_t;

    // F-register writes carry only flen meaningful bits; the upper bits are cleared.
    function automatic logic [WbDataW-1:0] wb_data_mask(
        input logic [AddrW-1:0]   addr,
        input logic [WbDataW-1:0] data,
        input int unsigned        flen
    );
        logic [WbDataW-1:0] keep;
        keep = {WbDataW{1'b1}} >> (WbDataW - flen);
        return addr[FSelBit] ? (data & keep) : data;
    endfunction

endpackage

// File: rtl/rv_g_wb_buf.sv
// Two-entry FIFO holding one execution unit's pending write-back results.
module rv_g_wb_buf
    import rv_g_pkg::*;
(
    input  logic    clk_i,
    input  logic    arst_ni,
    input  logic    push_i,
    input  logic    pop_i,
    input  wb_req_t data_i,
    output wb_req_t head_o,
    output logic    empty_o,
    output logic    ready_o
);

    logic [1:0] count_q, count_d;
    wb_req_t    ent0_q, ent0_d;
    wb_req_t    ent1_q, ent1_d;
    logic       ready_q, ready_d;
    logic       empty_q, empty_d;
    logic       do_push, do_pop;

    // Next-state: entry 0 is always the head, entry 1 shifts down on pop.
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        do_push = push_i && (count_q != 2'd2);
        do_pop  = pop_i && (count_q != 2'd0);

        unique case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = data_i;
                else                 ent1_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry: the new entry replaces the popped head.
                ent0_d = data_i;
            end
            default: ;
        endcase

        ready_d = (count_d != 2'd2);
        empty_d = (count_d == 2'd0);
    end

    // State register; ready and empty are kept as flops so neither is a combinational path.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            ready_q <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            ready_q <= ready_d;
            empty_q <= empty_d;
        end
    end

    assign head_o  = ent0_q;
    assign empty_o = empty_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/rv_g_wb_arbiter.sv
// Round-robin merge of execution-unit results onto the register-file write/unlock port.
module rv_g_wb_arbiter
    import rv_g_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    parameter  int unsigned XLEN    = DefXlen,
    parameter  int unsigned FLEN    = DefFlen,
    localparam int unsigned MaxLen  = (FLEN > XLEN) ? FLEN : XLEN
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*AddrW-1:0]  src_addr_i,
    input  logic [NUM_SRC*MaxLen-1:0] src_data_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    output logic                      wr_en_o,
    output logic [AddrW-1:0]          wr_addr_o,
    output logic [MaxLen-1:0]         wr_data_o,
    output logic                      busy_o
);

    localparam int unsigned IdxW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] push, pop, empty, ready;
    wb_req_t            heads [NUM_SRC];

    logic [IdxW-1:0]    rr_q, rr_d;
    logic               wr_en_q, wr_en_d;
    logic [AddrW-1:0]   wr_addr_q, wr_addr_d;
    logic [MaxLen-1:0]  wr_data_q, wr_data_d;
    logic               busy_q, busy_d;

    logic [IdxW:0]      pick;
    logic               gnt_vld;
    logic [IdxW-1:0]    gnt_idx;
    logic [1:0]         cnt, cnt_nxt;

    // First requester at or after rr, wrapping; MSB of the result flags a grant.
    function automatic logic [IdxW:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [IdxW-1:0]    rr
    );
        logic            found;
        logic [IdxW-1:0] k;
        logic [IdxW-1:0] idx;
        found = 1'b0;
        k     = '0;
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            idx = IdxW'((32'(rr) + off) % NUM_SRC);
            if (!found && req[idx]) begin
                found = 1'b1;
                k     = idx;
            end
        end
        return {found, k};
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_req_t req_in;
        assign req_in  = {src_addr_i[i*AddrW +: AddrW], src_data_i[i*MaxLen +: MaxLen]};
        assign push[i] = src_valid_i[i] & ready[i];

        rv_g_wb_buf u_buf (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .data_i  (req_in),
            .head_o  (heads[i]),
            .empty_o (empty[i]),
            .ready_o (ready[i])
        );
    end

    // Grant, pointer advance, output-register next values and busy look-ahead.
    always_comb begin
        rr_d      = rr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop       = '0;
        busy_d    = 1'b0;
        cnt       = 2'd0;
        cnt_nxt   = 2'd0;

        pick    = rr_pick(~empty, rr_q);
        gnt_vld = pick[IdxW];
        gnt_idx = pick[IdxW-1:0];

        if (gnt_vld) begin
            pop[gnt_idx] = 1'b1;
            rr_d = (gnt_idx == IdxW'(NUM_SRC - 1)) ? '0 : gnt_idx + IdxW'(1);
            // x0 results are retired silently; they still consume the slot.
            if (heads[gnt_idx].addr != AddrX0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = heads[gnt_idx].addr;
                wr_data_d = wb_data_mask(heads[gnt_idx].addr, heads[gnt_idx].data, FLEN);
            end
        end

        // Buffer occupancy is recovered from its empty/ready flops.
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cnt     = empty[i] ? 2'd0 : (ready[i] ? 2'd1 : 2'd2);
            cnt_nxt = cnt + {1'b0, push[i]} - {1'b0, pop[i]};
            if (cnt_nxt != 2'd0) busy_d = 1'b1;
        end
        if (wr_en_d) busy_d = 1'b1;
    end

    // Pointer and registered write port.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rr_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign src_ready_o = ready;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
// Self-checking bench for rv_g_wb_arbiter: directed table, corner sequences, random vs. queue model.
module tb_rv_g_wb_arbiter;
    import rv_g_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk_i;
    logic            arst_ni;
    logic [N-1:0]    src_valid_i;
    logic [N*6-1:0]  src_addr_i;
    logic [N*DW-1:0] src_data_i;
    logic [N-1:0]    src_ready_o;
    logic            wr_en_o;
    logic [5:0]      wr_addr_o;
    logic [DW-1:0]   wr_data_o;
    logic            busy_o;

    rv_g_wb_arbiter #(.NUM_SRC(N), .XLEN(64), .FLEN(32)) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .src_valid_i (src_valid_i),
        .src_addr_i  (src_addr_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct { logic [5:0] addr; logic [63:0] data; } ent_t;
    typedef struct {
        int         src;
        logic [5:0] addr;
        logic [63:0] data;
        logic       exp_en;
        logic [5:0] exp_addr;
        logic [63:0] exp_data;
    } vec_t;

    // Reference model: one FIFO queue per source, pointer as plain integer.
    ent_t        mq [N][$];
    int          m_rr;
    logic        m_en;
    logic [5:0]  m_addr;
    logic [63:0] m_data;

    // Stimulus currently presented, and whether it was taken at the last edge.
    logic [N-1:0] v;
    logic [N-1:0] acc;
    logic [5:0]   a [N];
    logic [63:0]  d [N];
    int           wcount [64];

    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            src_valid_i[i]          = v[i];
            src_addr_i[i*6 +: 6]    = a[i];
            src_data_i[i*DW +: DW]  = d[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // One clock: drive, advance the model by the specification rules, compare everything.
    task automatic step();
        logic [N-1:0] rdy;
        logic [N-1:0] exp_rdy;
        bit   found;
        int   k, idx;
        ent_t e;
        logic busy;
        apply();
        for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < 2);
        @(posedge clk_i);
        #1;
        found = 0; k = 0;
        for (int off = 0; off < N; off++) begin
            idx = (m_rr + off) % N;
            if (!found && mq[idx].size() > 0) begin found = 1; k = idx; end
        end
        m_en = 1'b0;
        if (found) begin
            e = mq[k].pop_front();
            m_rr = (k + 1) % N;
            if (e.addr != 6'd0) begin
                m_en   = 1'b1;
                m_addr = e.addr;
                m_data = e.addr[5] ? (e.data & 64'h0000_0000_FFFF_FFFF) : e.data;
            end
        end
        for (int i = 0; i < N; i++) begin
            acc[i] = v[i] && rdy[i];
            if (acc[i]) mq[i].push_back('{a[i], d[i]});
        end
        busy = m_en;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = (mq[i].size() < 2);
            if (mq[i].size() > 0) busy = 1'b1;
        end
        if (wr_en_o === 1'b1) wcount[wr_addr_o]++;
        check("wr_en", 64'(wr_en_o), 64'(m_en));
        check("wr_addr", 64'(wr_addr_o), 64'(m_addr));
        check("wr_data", wr_data_o, m_data);
        check("src_ready", 64'(src_ready_o), 64'(exp_rdy));
        check("busy", 64'(busy_o), 64'(busy));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
        check({tag, "_wr_data"}, wr_data_o, 64'd0);
        check({tag, "_ready"}, 64'(src_ready_o), 64'hF);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    task automatic do_reset();
        arst_ni = 1'b0;
        v = '0; acc = '0;
        apply();
        #1;
        check_reset_vals("rst");
        @(negedge clk_i);
        arst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 64; i++) wcount[i] = 0;
    endtask

    // Address not present in any buffer nor offered by another source this cycle.
    function automatic logic [5:0] pick_addr(input int src);
        logic [5:0] c;
        bit ok;
        if ($urandom_range(7) == 0) return 6'd0;
        for (int tries = 0; tries < 1000; tries++) begin
            c  = 6'($urandom_range(63, 1));
            ok = 1;
            for (int j = 0; j < N; j++) begin
                foreach (mq[j][q]) if (mq[j][q].addr == c) ok = 0;
                if (j != src && v[j] && a[j] == c) ok = 0;
            end
            if (ok) return c;
        end
        return 6'd0;
    endfunction

    // Random cycle; an offer that was not accepted is held unchanged.
    task automatic rand_cycle(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!(v[i] && !acc[i])) begin
                v[i] = 1'b0;
                if ($urandom_range(99) < pct) begin
                    a[i] = pick_addr(i);
                    d[i] = {$urandom, $urandom};
                    v[i] = 1'b1;
                end
            end
        end
        step();
    endtask

    vec_t tbl [6];

    initial begin
        checks = 0; errors = 0;
        v = '0; acc = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        for (int i = 0; i < 64; i++) wcount[i] = 0;
        src_valid_i = '0; src_addr_i = '0; src_data_i = '0;
        arst_ni = 1'b0;
        model_reset();

        tbl[0] = '{1, 6'd5,  64'h0000_0000_0000_00AB, 1'b1, 6'd5,  64'h0000_0000_0000_00AB};
        tbl[1] = '{0, 6'h21, 64'hFFFF_FFFF_1234_5678, 1'b1, 6'h21, 64'h0000_0000_1234_5678};
        tbl[2] = '{3, 6'h20, 64'hDEAD_BEEF_0000_0001, 1'b1, 6'h20, 64'h0000_0000_0000_0001};
        tbl[3] = '{2, 6'd0,  64'h1111_2222_3333_4444, 1'b0, 6'd0,  64'd0};
        tbl[4] = '{2, 6'h3F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'h3F, 64'h0000_0000_FFFF_FFFF};
        tbl[5] = '{0, 6'd31, 64'h8000_0000_0000_0001, 1'b1, 6'd31, 64'h8000_0000_0000_0001};

        #12;
        check_reset_vals("init");
        @(negedge clk_i);
        arst_ni = 1'b1;

        // Single-source table: push, write two cycles later, idle one cycle after.
        step(); step();
        for (int t = 0; t < 6; t++) begin
            v = '0;
            v[tbl[t].src] = 1'b1;
            a[tbl[t].src] = tbl[t].addr;
            d[tbl[t].src] = tbl[t].data;
            step();
            v = '0;
            step();
            check($sformatf("tbl%0d_en", t), 64'(wr_en_o), 64'(tbl[t].exp_en));
            if (tbl[t].exp_en) begin
                check($sformatf("tbl%0d_addr", t), 64'(wr_addr_o), 64'(tbl[t].exp_addr));
                check($sformatf("tbl%0d_data", t), wr_data_o, tbl[t].exp_data);
            end
            step();
            check($sformatf("tbl%0d_idle", t), 64'(busy_o), 64'd0);
        end

        // x0 consumes the grant: the pointer moves past source 0.
        do_reset();
        v = 4'b0001; a[0] = 6'd0; d[0] = 64'h55;
        step();
        v = '0;
        step();
        check("x0_no_write", 64'(wr_en_o), 64'd0);
        v = 4'b0011; a[0] = 6'd7; a[1] = 6'd8; d[0] = 64'h77; d[1] = 64'h88;
        step();
        v = '0;
        step();
        check("x0_rr_first", 64'(wr_addr_o), 64'd8);
        step();
        check("x0_rr_second", 64'(wr_addr_o), 64'd7);
        step();

        // All sources once: writes come out in source order.
        do_reset();
        v = 4'b1111;
        for (int i = 0; i < N; i++) begin a[i] = 6'(i + 1); d[i] = 64'(i * 16 + 3); end
        step();
        v = '0;
        for (int i = 0; i < N; i++) begin
            step();
            check($sformatf("order_%0d", i), 64'(wr_addr_o), 64'(i + 1));
            check($sformatf("order_rdy_%0d", i), 64'(src_ready_o), 64'hF);
        end
        step();

        // Back-pressure on source 2 while three others compete.
        do_reset();
        v = 4'b1111;
        for (int i = 0; i < N; i++) begin a[i] = 6'(10 + i); d[i] = {$urandom, $urandom}; end
        step();
        for (int i = 0; i < N; i++) begin a[i] = 6'(20 + i); d[i] = {$urandom, $urandom}; end
        step();
        check("bp_full", 64'(src_ready_o[2]), 64'd0);
        v = '0;
        step();
        check("bp_still_full", 64'(src_ready_o[2]), 64'd0);
        step();
        check("bp_grant_addr", 64'(wr_addr_o), 64'd12);
        check("bp_reassert", 64'(src_ready_o[2]), 64'd1);
        for (int i = 0; i < 10; i++) step();
        check("bp_once_12", 64'(wcount[12]), 64'd1);
        check("bp_once_22", 64'(wcount[22]), 64'd1);
        check("bp_drained", 64'(busy_o), 64'd0);

        // Reset with five results buffered and a write on the port.
        do_reset();
        v = 4'b1111;
        for (int i = 0; i < N; i++) begin a[i] = 6'(40 + i); d[i] = {$urandom, $urandom}; end
        step();
        v = 4'b0011; a[0] = 6'd44; a[1] = 6'd45;
        step();
        check("mid_wr_en", 64'(wr_en_o), 64'd1);
        v = '0;
        apply();
        #2;
        arst_ni = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk_i);
        arst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step();
        check("post_rst_idle", 64'(busy_o), 64'd0);

        // Random traffic across load levels against the queue model.
        do_reset();
        for (int phase = 0; phase < 4; phase++) begin
            for (int c = 0; c < 600; c++) rand_cycle(phase == 0 ? 10 : phase == 1 ? 40 : phase == 2 ? 80 : 100);
        end
        for (int i = 0; i < N; i++) if (v[i] && !acc[i]) ; else v[i] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < N; i++) if (acc[i]) v[i] = 1'b0;
            step();
        end
        check("rand_drained", 64'(busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
